// File: rtl/hp_filter_settle.sv
// hp_filter_settle: DC-blocking high-pass filter (leaky-accumulator baseline) with seed/rescale settling FSM
module hp_filter_settle #(
  parameter int R = 14,
  parameter int S = 64,
  parameter int SETTLE_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          tau,
  input  logic                seed,
  input  logic signed [R-1:0] in,
  output logic signed [R-1:0] out,
  output logic                settled,
  output logic                sat
);
  localparam int CW = $clog2(SETTLE_CYC + 2);
  localparam logic signed [S-13:0] DMAX = (S-13)'(2**(R-1) - 1);
  localparam logic signed [S-13:0] DMIN = ~DMAX;
  typedef enum logic [1:0] {SEED, TRACK, RESCALE} state_t;
  state_t                state;
  logic signed [S-1:0]   acc;
  logic [3:0]            k_q;
  logic [CW-1:0]         cnt;
  logic                  settled_q;
  logic                  bypass;
  logic [4:0]            sh_q, sh_new;
  logic signed [S-15:0]  base;
  logic signed [S-13:0]  diff;
  logic signed [R-1:0]   out_sat;
  logic                  out_clip;
  logic [S:0]            acc_trk, acc_rsc;
  logic signed [S-1:0]   acc_seed;
  logic [CW-1:0]         cnt_inc;
  // {clip, value}: clamp a wide signed value into the S-bit accumulator range
  function automatic logic [S:0] sat_acc(input logic signed [S+15:0] v);
    logic clip;
    clip = !((&v[S+15:S-1]) || !(|v[S+15:S-1]));
    return clip ? {1'b1, v[S+15], {(S-1){~v[S+15]}}} : {1'b0, v[S-1:0]};
  endfunction
  assign bypass   = |tau[5:4];
  assign settled  = settled_q & ~bypass;
  assign sh_q     = 5'd14 + {1'b0, k_q};
  assign sh_new   = 5'd14 + {1'b0, tau[3:0]};
  assign base     = (S-14)'(acc >>> sh_q);
  assign diff     = (S-13)'(in) - (S-13)'(base);
  assign out_clip = (diff > DMAX) || (diff < DMIN);
  assign out_sat  = diff > DMAX ? R'(DMAX) : diff < DMIN ? R'(DMIN) : R'(diff);
  assign acc_trk  = sat_acc((S+16)'(acc) + (S+16)'(in) - (S+16)'(base));
  assign acc_rsc  = sat_acc((S+16)'(base) <<< sh_new);
  assign acc_seed = S'(in) <<< sh_new;
  assign cnt_inc  = cnt + CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out       <= '0;
      sat       <= 1'b0;
      settled_q <= 1'b0;
      cnt       <= '0;
      k_q       <= '0;
      state     <= SEED;
    end else if (bypass) begin
      out <= in;
      sat <= 1'b0;
    end else begin
      unique case (state)
        SEED: begin
          acc       <= acc_seed;
          out       <= '0;
          sat       <= 1'b0;
          cnt       <= '0;
          k_q       <= tau[3:0];
          settled_q <= 1'b0;
          state     <= TRACK;
        end
        TRACK: begin
          acc       <= acc_trk[S-1:0];
          out       <= out_sat;
          sat       <= acc_trk[S] | out_clip;
          cnt       <= cnt_inc > CW'(SETTLE_CYC) ? CW'(SETTLE_CYC) : cnt_inc;
          settled_q <= cnt_inc >= CW'(SETTLE_CYC);
          state     <= seed ? SEED : (tau[3:0] != k_q) ? RESCALE : TRACK;
        end
        RESCALE: begin
          acc       <= acc_rsc[S-1:0];
          out       <= out_sat;
          sat       <= acc_rsc[S] | out_clip;
          k_q       <= tau[3:0];
          cnt       <= '0;
          settled_q <= 1'b0;
          state     <= TRACK;
        end
        default: state <= SEED;
      endcase
    end
  end
endmodule

// File: tb/tb_hp_filter_settle.sv
// tb_hp_filter_settle: directed self-checking bench for hp_filter_settle
module tb_hp_filter_settle;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [5:0]        tau = 6'd0;
  logic              seed = 1'b0;
  logic signed [13:0] in = 14'sd5000;
  logic signed [13:0] out;
  logic              settled;
  logic              sat;
  int                passed = 0;
  int                total = 0;
  int                n;

  hp_filter_settle #(.R(14), .S(64), .SETTLE_CYC(1024)) dut (
    .clk(clk), .rst(rst), .tau(tau), .seed(seed), .in(in),
    .out(out), .settled(settled), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) begin
      passed++;
    end else begin
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_settled(output int cnt);
    cnt = 0;
    while (!settled && cnt < 3000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_out", int'(out), 0, 0);
    chk("rst_settled", int'(settled), 0, 0);
    chk("rst_sat", int'(sat), 0, 0);
    rst = 1'b0;
    tick();
    chk("seed_out", int'(out), 0, 0);
    chk("seed_settled", int'(settled), 0, 0);
    wait_settled(n);
    chk("settle_cnt", n, 1024, 1024);
    chk("dc_out", int'(out), -1, 1);
    repeat (5) tick();
    chk("settled_holds", int'(settled), 1, 1);
    // step response with k=0 from a zero baseline
    seed = 1'b1; in = 14'sd0;
    tick();
    seed = 1'b0;
    tick();
    chk("reseed_settled", int'(settled), 0, 0);
    in = 14'sd1000;
    tick();
    chk("step_out", int'(out), 1000, 1000);
    repeat (16383) tick();
    chk("step_tau1", int'(out), 366, 370);
    repeat (49152) tick();
    chk("step_tau4", int'(out), 0, 19);
    // output saturation
    seed = 1'b1; in = -14'sd8192;
    tick();
    seed = 1'b0;
    tick();
    in = 14'sd8191;
    tick();
    chk("sat_out", int'(out), 8191, 8191);
    chk("sat_flag", int'(sat), 1, 1);
    in = -14'sd1000;
    tick();
    chk("unsat_out", int'(out), 7192, 7192);
    chk("unsat_flag", int'(sat), 0, 0);
    // seed and tau change together: SEED wins, no RESCALE
    seed = 1'b1; tau = 6'd2; in = 14'sd2000;
    tick();
    seed = 1'b0;
    tick();
    chk("prio_out", int'(out), 0, 0);
    chk("prio_settled", int'(settled), 0, 0);
    wait_settled(n);
    chk("prio_settle_cnt", n, 1024, 1024);
    chk("k2_out", int'(out), 0, 0);
    // tau change 2 -> 5 keeps the baseline
    tau = 6'd5;
    tick();
    tick();
    chk("rescale_out", int'(out), -2, 2);
    chk("rescale_settled", int'(settled), 0, 0);
    wait_settled(n);
    chk("rescale_settle_cnt", n, 1024, 1024);
    chk("k5_out", int'(out), -2, 2);
    // bypass holds the filter state
    tau = 6'd21; in = 14'sd1234;
    tick();
    chk("byp_out", int'(out), 1234, 1234);
    chk("byp_settled", int'(settled), 0, 0);
    chk("byp_sat", int'(sat), 0, 0);
    in = -14'sd7000;
    tick();
    chk("byp_out_neg", int'(out), -7000, -7000);
    tau = 6'd5; in = 14'sd2000;
    tick();
    chk("byp_exit_out", int'(out), 0, 0);
    chk("byp_exit_settled", int'(settled), 1, 1);
    // k change made during bypass is rescaled on exit
    tau = 6'd16; in = 14'sd1234;
    tick();
    tau = 6'd2; in = 14'sd2000;
    tick();
    tick();
    chk("byp_rescale_out", int'(out), -2, 2);
    chk("byp_rescale_settled", int'(settled), 0, 0);
    tick();
    chk("byp_rescale_track", int'(out), -2, 2);
    // reset mid-operation
    in = 14'sd3000; rst = 1'b1;
    tick();
    chk("mid_rst_out", int'(out), 0, 0);
    chk("mid_rst_settled", int'(settled), 0, 0);
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hp_filter_settle.md
Name: hp_filter_settle

Overview:
- First-order DC-blocking high-pass filter; the complementary operation to the team's accumulator-based low-pass filter.
- Tracks a running baseline with a leaky accumulator and outputs the input minus that baseline.
- Adds a seed/rescale FSM so that a power-up or a time-constant change does not cause a large transient.
- Sits in the lock-in chain ahead of the demodulators, removing DC offset from ADC/error signals.

Parameters:
- R, 14, input/output width (signed); supported range 14..28.
- S, 64, accumulator width (signed); must satisfy S >= R+30.
- SETTLE_CYC, 1024, number of TRACK cycles before `settled` asserts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tau  in  6  tau[3:0]=k shift (time constant 8 ns*2^(14+k)); tau[5:4]!=0 selects bypass
- seed  in  1  single-cycle pulse: re-seed baseline to the current input
- in  in  R  signed sample, one per clk
- out  out  R  signed high-passed sample, registered
- settled  out  1  high once filter has tracked SETTLE_CYC cycles since last seed/rescale
- sat  out  1  one-cycle pulse, aligned with `out`, when out or acc clipped this update

Behaviour:
- Reset (rst=1, highest priority):
  - acc=0, out=0, sat=0, settled=0, cnt=0, k_q=0, state=SEED.
  - rst asserted mid-operation aborts any state on the next edge.
- Baseline:
  - base = acc >>> (14+k_q), arithmetic shift, width S-14.
  - k_q is the registered, active k.
- Difference:
  - diff = in - base, computed at R+1 bits minimum.
  - out <= diff saturated to [-2^(R-1), 2^(R-1)-1].
  - Latency is 1 cycle: out at edge n+1 reflects in and acc at edge n.
- States:
  - SEED: acc <= sext(in) << (14+k_new); out <= 0; cnt <= 0; k_q <= k_new; settled <= 0. Next state TRACK.
  - TRACK: acc <= sat_S(acc + in - base); out <= sat(diff); cnt <= min(cnt+1, SETTLE_CYC); settled <= (cnt+1 >= SETTLE_CYC).
    - seed=1 -> next state SEED.
    - Else if tau[3:0] != k_q -> next state RESCALE.
  - RESCALE, exactly one cycle:
    - acc <= sext(base_old) << (14+tau[3:0]), so the baseline value is preserved across the change.
    - out <= sat(in - base_old); k_q <= tau[3:0]; cnt <= 0; settled <= 0.
    - Next state TRACK. A further tau change is picked up from TRACK on the following cycle.
- Bypass (tau[5:4]!=0):
  - out <= in; acc, cnt, k_q and state hold; sat <= 0.
  - settled output = settled_reg & ~bypass.
  - Leaving bypass resumes TRACK with the held acc. A k change made during bypass is detected on exit and handled by RESCALE.
- Priorities:
  - rst > bypass > seed > tau change.
  - seed and a tau change in the same cycle -> SEED, using the new k; no RESCALE afterwards.
  - seed while in SEED or RESCALE is ignored.
- Saturation:
  - acc clips to +/-(2^(S-1)) limits without wrap.
  - sat=1 for that cycle if either the acc or the out clip occurs; otherwise 0.
- cnt saturates at SETTLE_CYC and never wraps.
- tau input is sampled every cycle; no handshake.

Test Plan:
- Reset: hold rst 3 cycles with in=5000 -> out=0, settled=0, sat=0. Release -> SEED cycle, out=0. Subsequently out stays 0 ±1 with in=5000 constant.
- Settle count: after reset release with k=0, SETTLE_CYC=1024 -> settled rises exactly 1024 TRACK cycles after SEED, and stays high.
- Step response, k=0, baseline 0:
  - in steps 0->1000 -> out=1000 one cycle later.
  - After 16384 cycles out = 368 ±2.
  - After 65536 cycles out <= 19.
- Saturation: seed with in=-8192, then in=+8191 (R=14) -> out=8191 and sat=1 on the first TRACK output, then sat=0 once diff is in range.
- Tau change: at steady baseline 2000 with k=2, change tau to 5 -> one RESCALE cycle; base after = 2000 ±1; out step <= 2; settled drops to 0 and re-asserts after 1024 cycles.
- Bypass and priority:
  - tau=6'd16 -> out=in next cycle, settled=0; acc unchanged on return to tau=2.
  - seed and tau change in the same cycle -> SEED taken, k_q = new k, no RESCALE.
